// File: rtl/seg_reader_pkg.sv
// seg_reader_pkg: shared 7-segment pattern constants and reader FSM states
package seg_reader_pkg;

    // Segment patterns, bit6..bit0 = g..a, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {IDLE, SETTLING, LOCKED, BLANK} state_t;

endpackage

// File: rtl/seg_decode.sv
// seg_decode: one 7-segment digit pattern to BCD with a validity flag
module seg_decode
    import seg_reader_pkg::*;
(
    input  logic [6:0] seg,
    input  logic       blank_as_zero,
    output logic [3:0] bcd,
    output logic       valid
);

    // Exact match against the shared pattern table; a dark digit is only legal when mapped to zero
    always_comb begin
        bcd   = 4'd0;
        valid = 1'b1;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: valid = blank_as_zero;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_reader.sv
// seg_reader: recovers the 3-digit BCD count from the display segment buses once they settle
module seg_reader
    import seg_reader_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter bit BLANK_AS_ZERO = 1'b0,
    parameter int ERR_CNT_W     = 8
)(
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic [6:0]           seg_in3,
    input  logic [6:0]           seg_in2,
    input  logic [6:0]           seg_in1,
    output logic [11:0]          bcd_out,
    output logic                 bcd_valid,
    output logic                 pattern_err,
    output logic [2:0]           err_digit,
    output logic                 disp_blank,
    output logic                 stable,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [7:0] SC = 8'(STABLE_CYCLES);

    logic [20:0] in_r;
    logic [20:0] held;
    logic [7:0]  cnt;
    state_t      state;
    logic [11:0] dec_bcd;
    logic [2:0]  dec_ok;
    logic        change;
    logic        commit;

    seg_decode u_d3 (.seg(held[20:14]), .blank_as_zero(BLANK_AS_ZERO), .bcd(dec_bcd[11:8]), .valid(dec_ok[2]));
    seg_decode u_d2 (.seg(held[13:7]),  .blank_as_zero(BLANK_AS_ZERO), .bcd(dec_bcd[7:4]),  .valid(dec_ok[1]));
    seg_decode u_d1 (.seg(held[6:0]),   .blank_as_zero(BLANK_AS_ZERO), .bcd(dec_bcd[3:0]),  .valid(dec_ok[0]));

    assign change = in_r != held;
    assign stable = cnt == SC;
    // Fires on the edge the counter reaches saturation; LOCKED/BLANK never see it until a new change
    assign commit = !change && cnt == SC - 8'd1 && (state == IDLE || state == SETTLING);

    // Two-deep input pipeline and stability counter, compared on pre-edge values
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            in_r <= '0;
            held <= '0;
            cnt  <= '0;
        end else begin
            in_r <= {seg_in3, seg_in2, seg_in1};
            held <= in_r;
            cnt  <= change ? 8'd0 : (cnt < SC ? cnt + 8'd1 : cnt);
        end
    end

    // Settle/commit FSM with registered strobes and status
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bcd_out     <= '0;
            bcd_valid   <= 1'b0;
            pattern_err <= 1'b0;
            err_digit   <= '0;
            disp_blank  <= 1'b0;
            err_cnt     <= '0;
        end else begin
            bcd_valid   <= 1'b0;
            pattern_err <= 1'b0;
            if (commit) begin
                if (held == '0) begin
                    state      <= BLANK;
                    disp_blank <= 1'b1;
                end else if (&dec_ok) begin
                    state     <= LOCKED;
                    bcd_out   <= dec_bcd;
                    bcd_valid <= 1'b1;
                    err_digit <= '0;
                end else begin
                    state       <= LOCKED;
                    pattern_err <= 1'b1;
                    err_digit   <= ~dec_ok;
                    err_cnt     <= &err_cnt ? err_cnt : err_cnt + ERR_CNT_W'(1);
                end
            end else if (change) begin
                state      <= SETTLING;
                disp_blank <= 1'b0;
            end
        end
    end

endmodule
